// File: rtl/alu_cmd_feeder_if.sv
// Command and result handshake bundle between the command source/consumer and alu_cmd_feeder.
// master = the environment side (offers commands, accepts results); slave = the feeder.
interface alu_cmd_feeder_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_clr;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_op;
  logic         res_chained;

  modport master (
    output cmd_valid, cmd_clr, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_op, res_chained
  );

  modport slave (
    input  cmd_valid, cmd_clr, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_op, res_chained
  );
endinterface

// File: rtl/alu_cmd_feeder.sv
// Command front end for the accumulating ALU: queues commands, issues one per committed
// cycle, keeps the accumulator stable while idle and captures each result for the consumer.
module alu_cmd_feeder #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          clear_n,
  alu_cmd_feeder_if.slave bus,
  output logic          alu_clear,
  output logic [W-1:0]  alu_input1,
  output logic [W-1:0]  alu_input2,
  output logic [2:0]    alu_opcode,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_has_last_res,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic {
    ST_CLR,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic         clr;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  cmd_t          head;
  logic          empty;
  logic          full;
  logic          push;
  logic          fire;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  shadow;

  logic          res_valid_q;
  logic [W-1:0]  res_data_q;
  logic [2:0]    res_op_q;
  logic          res_chained_q;

  assign empty         = (count == '0);
  assign full          = (count == CW'(DEPTH));
  assign head          = mem[rd_ptr];
  assign bus.cmd_ready = clear_n & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;
  // A held result blocks issue unless it is being drained on the same edge.
  assign fire          = clear_n & ~empty & (~res_valid_q | bus.res_ready);

  assign fifo_count      = count;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_op      = res_op_q;
  assign bus.res_chained = res_chained_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{clr: bus.cmd_clr, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= ST_CLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Idle in RUN replays OR(0, shadow) so the accumulator reproduces itself unchanged.
  always_comb begin
    state_nxt  = state;
    alu_clear  = 1'b0;
    alu_opcode = OP_ADD;
    alu_input1 = '0;
    alu_input2 = '0;
    if (!clear_n) begin
      alu_clear = 1'b1;
      state_nxt = ST_CLR;
    end else if (fire) begin
      if (head.clr) begin
        alu_clear = 1'b1;
        state_nxt = ST_CLR;
      end else begin
        alu_opcode = head.op;
        alu_input1 = head.a;
        alu_input2 = head.b;
        state_nxt  = ST_RUN;
      end
    end else if (state == ST_CLR) begin
      alu_clear = 1'b1;
    end else begin
      alu_opcode = OP_OR;
      alu_input2 = shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      shadow        <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_op_q      <= '0;
      res_chained_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(fire);

      if (fire && !head.clr) begin
        res_valid_q   <= 1'b1;
        res_data_q    <= alu_out;
        res_op_q      <= head.op;
        res_chained_q <= alu_has_last_res;
        shadow        <= alu_out;
      end else begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_q <= 1'b0;
        end
        if (fire) begin
          shadow <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Scoreboard bench for alu_cmd_feeder: a behavioural accumulating ALU sits downstream and a
// command-sequence reference model predicts every result independently of feeder timing.
module tb_alu_cmd_feeder;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   op;
    logic         chained;
  } exp_t;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_feeder_if #(.W(W)) bus ();

  logic          alu_clear;
  logic [W-1:0]  alu_input1;
  logic [W-1:0]  alu_input2;
  logic [2:0]    alu_opcode;
  logic [W-1:0]  alu_out;
  logic          alu_has_last_res;
  logic [CW-1:0] fifo_count;

  alu_cmd_feeder #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk              (clk),
    .clear_n          (clear_n),
    .bus              (bus),
    .alu_clear        (alu_clear),
    .alu_input1       (alu_input1),
    .alu_input2       (alu_input2),
    .alu_opcode       (alu_opcode),
    .alu_out          (alu_out),
    .alu_has_last_res (alu_has_last_res),
    .fifo_count       (fifo_count)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int rr_mode = 0;

  // ALU algebra: chained operations use the accumulator in place of the first operand.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] r;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_MUL:  r = W'(x * y);
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [W-1:0] alu_acc = '0;
  logic         alu_has = 1'b0;
  assign alu_has_last_res = alu_has;
  assign alu_out = alu_has ? alu_fn(alu_opcode, alu_acc, alu_input1)
                           : alu_fn(alu_opcode, alu_input1, alu_input2);

  always @(posedge clk) begin
    if (alu_clear) begin
      alu_acc <= '0;
      alu_has <= 1'b0;
    end else if (alu_opcode != 3'd0) begin
      alu_acc <= alu_out;
      alu_has <= 1'b1;
    end
  end

  // Reference: results depend only on the order of accepted commands.
  exp_t         exp_q[$];
  logic [W-1:0] ref_acc = '0;
  logic         ref_has = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelAccept(input logic clr, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    exp_t e;
    if (clr) begin
      ref_has = 1'b0;
      ref_acc = '0;
    end else begin
      e.data    = ref_has ? alu_fn(op, ref_acc, a) : alu_fn(op, a, b);
      e.op      = op;
      e.chained = ref_has;
      exp_q.push_back(e);
      ref_acc = e.data;
      ref_has = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    bit accepted = 1'b0;
    int waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_clr   = clr;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    do begin
      @(negedge clk);
      accepted = (bus.cmd_ready === 1'b1);
      if (accepted) modelAccept(clr, op, a, b);
      @(posedge clk);
      #1;
      waited++;
    end while (!accepted && waited < 100);
    bus.cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    clear_n = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.delete();
    ref_has = 1'b0;
    ref_acc = '0;
    @(negedge clk);
    checkOutput("rst_alu_clear", 32'(alu_clear), 32'd1);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
    checkOutput("rst_res_op", 32'(bus.res_op), 32'd0);
    checkOutput("rst_res_chained", 32'(bus.res_chained), 32'd0);
    clear_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_alu_clear", 32'(alu_clear), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_count != '0 || bus.res_valid) && n < 100) begin
      idle(1);
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  always begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = 1'b0;
      default: bus.res_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: occupancy/handshake model built from the queue of accepted command kinds.
  bit   type_q[$];
  logic m_rv = 1'b0;
  bit   fire_m;
  bit   push_m;
  bit   op_fire_m;
  exp_t got;

  always @(negedge clk) begin
    if (started) begin
      checkOutput("fifo_count", 32'(fifo_count), 32'(type_q.size()));
      checkOutput("res_valid", 32'(bus.res_valid), 32'(m_rv));
      checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(clear_n && type_q.size() != DEPTH));
      fire_m = clear_n && type_q.size() > 0 && (!m_rv || bus.res_ready);
      if (!clear_n) checkOutput("alu_clear_in_reset", 32'(alu_clear), 32'd1);
      if (clear_n && !fire_m) begin
        checkOutput("idle_alu_clear", 32'(alu_clear), 32'(!alu_has));
        if (alu_has) checkOutput("idle_hold_alu_out", 32'(alu_out), 32'(alu_acc));
      end
      if (clear_n && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL res_unexpected: got data 0x%0h, expected no result at %0t",
                   bus.res_data, $time);
        end else begin
          got = exp_q.pop_front();
          checkOutput("res_data", 32'(bus.res_data), 32'(got.data));
          checkOutput("res_op", 32'(bus.res_op), 32'(got.op));
          checkOutput("res_chained", 32'(bus.res_chained), 32'(got.chained));
        end
      end
      if (!clear_n) begin
        type_q.delete();
        m_rv = 1'b0;
      end else begin
        push_m    = bus.cmd_valid && type_q.size() != DEPTH;
        op_fire_m = fire_m && !type_q[0];
        if (fire_m) void'(type_q.pop_front());
        if (push_m) type_q.push_back(bus.cmd_clr);
        m_rv = op_fire_m ? 1'b1 : ((m_rv && bus.res_ready) ? 1'b0 : m_rv);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_clr   = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    applyReset();

    // Accumulate: 3+4, idle hold, then chained +1.
    applyStimulus(1'b1, OP_ADD, 8'd0, 8'd0);
    applyStimulus(1'b0, OP_ADD, 8'd3, 8'd4);
    idle(3);
    applyStimulus(1'b0, OP_ADD, 8'd1, 8'd0);
    waitDrain();

    // Subtract, idle, chained subtract.
    applyStimulus(1'b1, OP_ADD, 8'd0, 8'd0);
    applyStimulus(1'b0, OP_SUB, 8'd15, 8'd1);
    idle(3);
    applyStimulus(1'b0, OP_SUB, 8'd1, 8'd0);
    waitDrain();

    // Back-pressure: one commits, four queue, then FIFO is full.
    rr_mode = 1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, OP_ADD, 8'(i + 1), 8'd2);
    checkOutput("full_fifo_count", 32'(fifo_count), 32'd4);
    checkOutput("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_clr   = 1'b0;
    bus.cmd_op    = OP_XOR;
    idle(3);
    bus.cmd_valid = 1'b0;
    checkOutput("full_no_push", 32'(fifo_count), 32'd4);
    rr_mode = 0;
    waitDrain();

    // Simultaneous push and pop at count 2, then a wrapping run.
    rr_mode = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, OP_XOR, 8'(8'h10 << i), 8'h0F);
    rr_mode = 0;
    applyStimulus(1'b0, OP_AND, 8'hF0, 8'h3C);
    checkOutput("pushpop_count", 32'(fifo_count), 32'd2);
    waitDrain();
    for (int i = 0; i < 2 * DEPTH + 1; i++) applyStimulus(1'b0, OP_ADD, 8'(i), 8'(3 * i));
    waitDrain();

    // Reset with queued commands and a held result.
    rr_mode = 1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, OP_MUL, 8'(i + 2), 8'd5);
    checkOutput("pre_rst_count", 32'(fifo_count), 32'd3);
    applyReset();
    rr_mode = 0;
    applyStimulus(1'b0, OP_ADD, 8'd2, 8'd2);
    waitDrain();

    // OR chain through an idle hold.
    applyStimulus(1'b1, OP_ADD, 8'd0, 8'd0);
    applyStimulus(1'b0, OP_OR, 8'h80, 8'h01);
    idle(2);
    applyStimulus(1'b0, OP_OR, 8'h40, 8'h33);
    waitDrain();

    // Randomised traffic with random consumer stalls.
    rr_mode = 2;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 7) == 0, 3'($urandom_range(1, 7)),
                    8'($urandom), 8'($urandom));
    end
    rr_mode = 0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
